// File: rtl/tempsense_ctrl_if.sv
// Register/cell-side bundle for the tempsense sequencer.
// Latency: none (wires only).
// Backpressure: none; start is a level request sampled by the controller in IDLE.
interface tempsense_ctrl_if #(
  parameter int DAC_RESOLUTION = 6,
  parameter int CNT_WIDTH      = 12
);
  logic                      i_start;
  logic [DAC_RESOLUTION-1:0] i_dac_val;
  logic [DAC_RESOLUTION-1:0] o_dac_data;
  logic                      o_dac_en;
  logic                      o_precharge_n;
  logic                      i_tempdelay;
  logic                      o_busy;
  logic                      o_done;
  logic [CNT_WIDTH-1:0]      o_result;
  logic                      o_overflow;
  logic                      o_error;

  // Register interface and delay cell: drive requests/cell output, observe results.
  modport master (
    output i_start, i_dac_val, i_tempdelay,
    input  o_dac_data, o_dac_en, o_precharge_n, o_busy, o_done,
    input  o_result, o_overflow, o_error
  );

  // Controller side.
  modport slave (
    input  i_start, i_dac_val, i_tempdelay,
    output o_dac_data, o_dac_en, o_precharge_n, o_busy, o_done,
    output o_result, o_overflow, o_error
  );
endinterface

// File: rtl/tempsense_ctrl.sv
// Sequencer + time-to-digital converter for the tempsense delay cell.
// Latency: 1 accept + SETTLE_CYCLES settle + (delay+2) measure + 1 done cycle.
// Backpressure: starts arriving while busy (or during the done cycle) are dropped.
module tempsense_ctrl #(
  parameter int DAC_RESOLUTION = 6,
  parameter int CNT_WIDTH      = 12,
  parameter int SETTLE_CYCLES  = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  tempsense_ctrl_if.slave bus
);

  // Settle counter sized independently so SETTLE_CYCLES may exceed the delay counter range.
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]        SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                    state_q;
  logic [SW-1:0]             scnt_q;
  logic [CNT_WIDTH-1:0]      cnt_q;
  logic                      sync1_q;
  logic                      sync2_q;
  logic [DAC_RESOLUTION-1:0] dac_data_q;
  logic                      dac_en_q;
  logic                      precharge_n_q;
  logic                      busy_q;
  logic                      done_q;
  logic [CNT_WIDTH-1:0]      result_q;
  logic                      overflow_q;
  logic                      error_q;

  // Two-flop synchronizer for the asynchronous cell output; resets to "not yet fallen".
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.i_tempdelay;
      sync2_q <= sync1_q;
    end
  end

  // Conversion sequencer with registered cell controls and results.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      scnt_q        <= '0;
      cnt_q         <= '0;
      dac_data_q    <= '0;
      dac_en_q      <= 1'b0;
      precharge_n_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      overflow_q    <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_start) begin
            dac_data_q <= bus.i_dac_val;
            scnt_q     <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b1;
            dac_en_q   <= 1'b1;
            state_q    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (scnt_q == SETTLE_LAST) begin
            if (!sync2_q) begin
              // Cell output already low: it never precharged, so the delay is meaningless.
              error_q    <= 1'b1;
              overflow_q <= 1'b0;
              result_q   <= '0;
              done_q     <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              cnt_q         <= '0;
              precharge_n_q <= 1'b1;
              state_q       <= ST_MEASURE;
            end
          end else begin
            scnt_q <= scnt_q + SW'(1);
          end
        end
        ST_MEASURE: begin
          if (!sync2_q) begin
            // Synchronizer latency is left in the result on purpose.
            result_q <= cnt_q;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else if (cnt_q == CNT_MAX) begin
            result_q   <= CNT_MAX;
            overflow_q <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_DONE: begin
          done_q        <= 1'b0;
          dac_en_q      <= 1'b0;
          precharge_n_q <= 1'b0;
          busy_q        <= 1'b0;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_dac_data    = dac_data_q;
  assign bus.o_dac_en      = dac_en_q;
  assign bus.o_precharge_n = precharge_n_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_result      = result_q;
  assign bus.o_overflow    = overflow_q;
  assign bus.o_error       = error_q;

endmodule

// File: tb/tb_tempsense_ctrl.sv
// Directed + randomized bench for tempsense_ctrl: main instance (12-bit counter)
// and a narrow instance (4-bit counter) for saturation.
// Checks are immediate assertions against a delay-based reference model.
module tb_tempsense_ctrl;

  logic clk;
  logic rst;

  tempsense_ctrl_if #(.DAC_RESOLUTION(6), .CNT_WIDTH(12)) a ();
  tempsense_ctrl_if #(.DAC_RESOLUTION(6), .CNT_WIDTH(4))  b ();

  tempsense_ctrl #(.DAC_RESOLUTION(6), .CNT_WIDTH(12), .SETTLE_CYCLES(16)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (a.slave)
  );

  tempsense_ctrl #(.DAC_RESOLUTION(6), .CNT_WIDTH(4), .SETTLE_CYCLES(16)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b.slave)
  );

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  bit prech_seen = 0;
  logic [5:0] exp_dac = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: a fall N edges after precharge release reads back as N plus the
  // two synchronizer stages, saturating at the counter maximum.
  function automatic int ref_result(input int n, input int width);
    int mx;
    mx = (1 << width) - 1;
    return (n + 2 > mx) ? mx : n + 2;
  endfunction

  // Count done pulses, note any precharge release, and confirm the latched DAC code.
  always @(negedge clk) begin
    if (!rst) begin
      if (a.o_done) done_cnt++;
      if (a.o_precharge_n) prech_seen = 1'b1;
      if (a.o_busy) chk("dac_stable", a.o_dac_data, exp_dac);
    end
  end

  task automatic wait_prech(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a.o_precharge_n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input bit sel_b, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      cyc++;
      if ((sel_b ? b.o_done : a.o_done) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_nom(input logic [5:0] dac, input int n);
    bit ok;
    int cyc;
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    a.i_start = 1'b1; a.i_dac_val = dac; a.i_tempdelay = 1'b1; exp_dac = dac;
    @(posedge clk); #1;
    a.i_start = 1'b0; a.i_dac_val = ~dac;
    chk("nom_busy", a.o_busy, 1);
    chk("nom_flags_clr", {a.o_overflow, a.o_error}, 0);
    wait_prech(ok);
    chk("nom_prech_rise", ok, 1);
    repeat (n) @(posedge clk);
    #1 a.i_tempdelay = 1'b0;
    wait_done(1'b0, ok, cyc);
    chk("nom_done_seen", ok, 1);
    chk("nom_result", a.o_result, ref_result(n, 12));
    chk("nom_ovf", a.o_overflow, 0);
    chk("nom_err", a.o_error, 0);
    @(negedge clk);
    chk("nom_idle_ctrl", {a.o_busy, a.o_dac_en, a.o_precharge_n, a.o_done}, 0);
    chk("nom_done_once", done_cnt, d0 + 1);
    a.i_tempdelay = 1'b1;
  endtask

  initial begin
    bit ok;
    int cyc;
    int d0;
    rst = 1'b1;
    a.i_start = 1'b0; a.i_dac_val = '0; a.i_tempdelay = 1'b1;
    b.i_start = 1'b0; b.i_dac_val = 6'd3; b.i_tempdelay = 1'b1;

    // Reset state.
    #3;
    chk("rst_ctrl", {a.o_busy, a.o_done, a.o_dac_en, a.o_precharge_n}, 0);
    chk("rst_data", {a.o_dac_data, a.o_result, a.o_overflow, a.o_error}, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Nominal conversion: fall 10 edges after release, then the zero-delay boundary.
    run_nom(6'd4, 10);
    run_nom(6'd7, 0);

    // Randomized delays and DAC codes.
    for (int k = 0; k < 6; k++) begin
      run_nom(6'($urandom_range(0, 63)), int'($urandom_range(0, 40)));
    end

    // Cell never precharges: error after exactly the settle window.
    a.i_tempdelay = 1'b0;
    repeat (3) @(posedge clk);
    prech_seen = 1'b0;
    d0 = done_cnt;
    #1 a.i_start = 1'b1; a.i_dac_val = 6'd33; exp_dac = 6'd33;
    @(posedge clk); #1 a.i_start = 1'b0;
    wait_done(1'b0, ok, cyc);
    chk("err_done_seen", ok, 1);
    chk("err_latency", cyc, 17);
    chk("err_flag", a.o_error, 1);
    chk("err_result", a.o_result, 0);
    chk("err_ovf", a.o_overflow, 0);
    @(negedge clk);
    chk("err_no_prech", prech_seen, 0);
    chk("err_done_once", done_cnt, d0 + 1);
    a.i_tempdelay = 1'b1;

    // Starts while busy are ignored and do not disturb the latched code.
    d0 = done_cnt;
    @(posedge clk); #1 a.i_start = 1'b1; a.i_dac_val = 6'd20; exp_dac = 6'd20;
    @(posedge clk); #1 a.i_start = 1'b0; a.i_dac_val = 6'd45;
    repeat (5) @(posedge clk);
    #1 a.i_start = 1'b1;
    @(posedge clk); #1 a.i_start = 1'b0;
    wait_prech(ok);
    chk("busy_prech_rise", ok, 1);
    repeat (3) @(posedge clk);
    #1 a.i_start = 1'b1;
    @(posedge clk);
    #1 a.i_start = 1'b0; a.i_tempdelay = 1'b0;
    wait_done(1'b0, ok, cyc);
    chk("busy_result", a.o_result, ref_result(4, 12));
    chk("busy_dac", a.o_dac_data, 20);
    a.i_tempdelay = 1'b1;
    repeat (30) @(negedge clk);
    chk("busy_single_conv", done_cnt, d0 + 1);
    chk("busy_not_queued", a.o_busy, 0);

    // Back-to-back with start held high: delays 5 then 20.
    @(posedge clk); #1 a.i_start = 1'b1; a.i_dac_val = 6'd9; exp_dac = 6'd9;
    wait_prech(ok);
    repeat (5) @(posedge clk);
    #1 a.i_tempdelay = 1'b0;
    wait_done(1'b0, ok, cyc);
    chk("b2b_result1", a.o_result, ref_result(5, 12));
    a.i_tempdelay = 1'b1;
    @(negedge clk);
    chk("b2b_idle_gap", a.o_busy, 0);
    @(negedge clk);
    chk("b2b_restart", a.o_busy, 1);
    chk("b2b_flags_clr", {a.o_overflow, a.o_error}, 0);
    wait_prech(ok);
    repeat (20) @(posedge clk);
    #1 a.i_tempdelay = 1'b0;
    wait_done(1'b0, ok, cyc);
    chk("b2b_result2", a.o_result, ref_result(20, 12));
    chk("b2b_flags", {a.o_overflow, a.o_error}, 0);
    a.i_start = 1'b0; a.i_tempdelay = 1'b1;
    repeat (3) @(negedge clk);
    chk("b2b_stopped", a.o_busy, 0);

    // Saturation on the 4-bit instance with the cell output stuck high.
    @(posedge clk); #1 b.i_start = 1'b1;
    @(posedge clk); #1 b.i_start = 1'b0;
    wait_done(1'b1, ok, cyc);
    chk("ovf_done_seen", ok, 1);
    chk("ovf_latency", cyc, 33);
    chk("ovf_result", b.o_result, ref_result(100, 4));
    chk("ovf_flag", b.o_overflow, 1);
    chk("ovf_err", b.o_error, 0);
    @(negedge clk);
    chk("ovf_ctrl_off", {b.o_busy, b.o_dac_en, b.o_precharge_n}, 0);
    @(posedge clk); #1 b.i_start = 1'b1;
    @(posedge clk); #1 b.i_start = 1'b0;
    chk("ovf_clr_on_start", b.o_overflow, 0);
    chk("ovf_result_held", b.o_result, 15);
    wait_done(1'b1, ok, cyc);
    chk("ovf_again", b.o_overflow, 1);

    // Asynchronous reset in the middle of a measurement.
    @(posedge clk); #1 a.i_start = 1'b1; a.i_dac_val = 6'd12; exp_dac = 6'd12;
    @(posedge clk); #1 a.i_start = 1'b0;
    wait_prech(ok);
    chk("mrst_prech_rise", ok, 1);
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("mrst_ctrl", {a.o_busy, a.o_done, a.o_dac_en, a.o_precharge_n}, 0);
    chk("mrst_data", {a.o_dac_data, a.o_result, a.o_overflow, a.o_error}, 0);
    @(posedge clk); #3 rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("mrst_no_done", done_cnt, d0);
    chk("mrst_idle", a.o_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
